nv_ram_rwsp_4x128_fifo_ctrl: RTL

//  Valid/ready FIFO controller that drives an external 4x128 two-port RAM (registered read

---
 rtl/nv_ram_rwsp_4x128_fifo_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/nv_ram_rwsp_4x128_fifo_ctrl.sv
// Valid/ready FIFO controller for an external 4x128 two-port RAM with a registered read address
// and a registered data output; it hides the two-stage RAM read pipeline behind rd_pvld/rd_prdy.
module nv_ram_rwsp_4x128_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 128
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [31:0]      ram_pwrbus_ram_pd,
    output logic             idle
);

    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_C = {(AW+1){1'b0}};
    localparam logic [AW-1:0] PTR1_C = AW'(1'b1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   held_r;
    logic [AW:0]   pend_r;
    logic          s1_vld_r;
    logic          s2_vld_r;

    logic          push_s;
    logic          pop_s;
    logic          ore_s;
    logic          re_s;
    logic [AW:0]   held_nxt_s;
    logic [AW:0]   pend_nxt_s;

    // Handshakes and RAM pipeline advance, all derived from registered state.
    // held counts entries still inside the RAM pipeline, so an issued address is never overwritten.
    always_comb begin
        push_s     = wr_pvld & (held_r != FULL_C);
        pop_s      = s2_vld_r & rd_prdy;
        ore_s      = s1_vld_r & (~s2_vld_r | pop_s);
        re_s       = (pend_r != ZERO_C) & (~s1_vld_r | ore_s);
        held_nxt_s = held_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        pend_nxt_s = pend_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, re_s};
    end

    assign wr_prdy           = (held_r != FULL_C);
    assign rd_pvld           = s2_vld_r;
    assign rd_pd             = ram_dout;
    assign ram_we            = push_s;
    assign ram_wa            = wr_ptr_r;
    assign ram_di            = wr_pd;
    assign ram_re            = re_s;
    assign ram_ra            = rd_ptr_r;
    assign ram_ore           = ore_s;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
    assign idle              = (held_r == ZERO_C) & ~s1_vld_r & ~s2_vld_r;

    // Pointer, occupancy and pipeline-stage state.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            held_r   <= ZERO_C;
            pend_r   <= ZERO_C;
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR1_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (re_s) begin
                rd_ptr_r <= rd_ptr_r + PTR1_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            held_r   <= held_nxt_s;
            pend_r   <= pend_nxt_s;
            s1_vld_r <= re_s | (s1_vld_r & ~ore_s);
            s2_vld_r <= ore_s | (s2_vld_r & ~pop_s);
        end
    end

endmodule
